// File: rtl/pc_seq_pkg.sv
// Shared types for the program sequencer: FSM state and next-PC source select.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DONE  = 2'd2,
        SEQ_FAULT = 2'd3
    } seq_state_t;

    typedef enum logic [2:0] {
        SEL_ABS  = 3'd0,
        SEL_CALL = 3'd1,
        SEL_RET  = 3'd2,
        SEL_REL  = 3'd3,
        SEL_INC  = 3'd4,
        SEL_HOLD = 3'd5
    } pc_sel_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack for call/ret. LIFO of SD entries, each D bits wide.
// Callers must not push when full or pop when empty; those cases are ignored here.
module ret_stack #(
    parameter int unsigned D  = 9,
    parameter int unsigned SD = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [D-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [D-1:0] top
);

    localparam int unsigned PW = $clog2(SD + 1);
    localparam int unsigned IW = (SD > 1) ? $clog2(SD) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_m1;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [D-1:0]  mem [SD];

    assign full   = (ptr_q == PW'(SD));
    assign empty  = (ptr_q == '0);
    assign ptr_m1 = ptr_q - PW'(1);
    assign wr_idx = ptr_q[IW-1:0];
    assign rd_idx = ptr_m1[IW-1:0];
    // Top is only meaningful when not empty.
    assign top    = mem[rd_idx];

    // Occupancy pointer: clear wins, then push, then pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (clear) begin
            ptr_q <= '0;
        end else if (push && !full) begin
            ptr_q <= ptr_q + PW'(1);
        end else if (pop && !empty) begin
            ptr_q <= ptr_m1;
        end
    end

    // Entry storage; contents above the pointer are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (!clear && push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: owns the PC, the start/done run handshake, call/return via
// ret_stack, and a saturating count of non-stalled RUN cycles.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned D          = 9,
    parameter int unsigned HALT_ADDR  = 128,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned SD         = 4,
    parameter int unsigned CW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic          absjump_en,
    input  logic          reljump_en,
    input  logic          call_en,
    input  logic          ret_en,
    input  logic [D-1:0]  target,
    output logic [D-1:0]  prog_ctr,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [CW-1:0] cycle_cnt
);

    localparam logic [D-1:0] HALT_PC  = D'(HALT_ADDR);
    localparam logic [D-1:0] START_PC = D'(START_ADDR);

    seq_state_t    state_q, state_d;
    pc_sel_t       sel;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          start;
    logic          active;
    logic          at_halt;
    logic          stk_full, stk_empty;
    logic [D-1:0]  stk_top;
    logic          stk_push, stk_pop;
    logic          err;
    logic [D-1:0]  pc_inc;

    assign start   = (state_q != SEQ_RUN) && req;
    assign at_halt = (pc_q == HALT_PC);
    // A cycle that may advance the PC: running, not stalled, not parked on halt.
    assign active  = (state_q == SEQ_RUN) && !stall && !at_halt;
    assign pc_inc  = pc_q + D'(1);

    // Priority encoder: abs > call > ret > rel > increment.
    always_comb begin
        sel = SEL_HOLD;
        if (active) begin
            if (absjump_en)      sel = SEL_ABS;
            else if (call_en)    sel = SEL_CALL;
            else if (ret_en)     sel = SEL_RET;
            else if (reljump_en) sel = SEL_REL;
            else                 sel = SEL_INC;
        end
    end

    assign stk_push = (sel == SEL_CALL) && !stk_full;
    assign stk_pop  = (sel == SEL_RET) && !stk_empty;
    assign err      = ((sel == SEL_CALL) && stk_full) || ((sel == SEL_RET) && stk_empty);

    ret_stack #(
        .D  (D),
        .SD (SD)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .clear (start),
        .din   (pc_inc),
        .full  (stk_full),
        .empty (stk_empty),
        .top   (stk_top)
    );

    // Next PC; faulting call/ret leave the PC where it is.
    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            SEL_ABS:  pc_d = target;
            SEL_CALL: pc_d = stk_full ? pc_q : target;
            SEL_RET:  pc_d = stk_empty ? pc_q : stk_top;
            SEL_REL:  pc_d = pc_q + target;
            SEL_INC:  pc_d = pc_inc;
            default:  pc_d = pc_q;
        endcase
        if (start) pc_d = START_PC;
    end

    // Run FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEQ_RUN: begin
                if (!stall) begin
                    if (at_halt)  state_d = SEQ_DONE;
                    else if (err) state_d = SEQ_FAULT;
                end
            end
            default: begin
                if (req) state_d = SEQ_RUN;
            end
        endcase
    end

    // Saturating cycle counter, restarted at each run start.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (active && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State, PC and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign prog_ctr  = pc_q;
    assign cycle_cnt = cnt_q;
    assign busy      = (state_q == SEQ_RUN);
    assign done      = (state_q == SEQ_DONE);
    assign fault     = (state_q == SEQ_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default instance plus a wrap-around
// instance and a narrow-counter instance.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
    logic       stall = 1'b0;
    logic       absjump_en = 1'b0, reljump_en = 1'b0, call_en = 1'b0, ret_en = 1'b0;
    logic [8:0] target = '0;

    logic [8:0]  pc0, pc1, pc2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        fault0, fault1, fault2;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .stall(stall),
        .absjump_en(absjump_en), .reljump_en(reljump_en), .call_en(call_en),
        .ret_en(ret_en), .target(target), .prog_ctr(pc0), .busy(busy0),
        .done(done0), .fault(fault0), .cycle_cnt(cnt0)
    );

    pc_sequencer #(.D(9), .HALT_ADDR(5), .START_ADDR(510)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .stall(stall),
        .absjump_en(absjump_en), .reljump_en(reljump_en), .call_en(call_en),
        .ret_en(ret_en), .target(target), .prog_ctr(pc1), .busy(busy1),
        .done(done1), .fault(fault1), .cycle_cnt(cnt1)
    );

    pc_sequencer #(.CW(4)) u_dut2 (
        .clk(clk), .reset(reset), .req(req2), .stall(stall),
        .absjump_en(absjump_en), .reljump_en(reljump_en), .call_en(call_en),
        .ret_en(ret_en), .target(target), .prog_ctr(pc2), .busy(busy2),
        .done(done2), .fault(fault2), .cycle_cnt(cnt2)
    );

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run0();
        req0 = 1'b1;
        step(1);
        req0 = 1'b0;
    endtask

    task automatic clear_en();
        absjump_en = 1'b0; reljump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (pc0 !== 9'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || fault0 !== 1'b0
            || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL reset: pc=%0d busy=%b done=%b fault=%b cnt=%0d, want 0/0/0/0/0",
                     pc0, busy0, done0, fault0, cnt0);
        end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_straight();
        start_run0();
        checks++;
        if (busy0 !== 1'b1 || pc0 !== 9'd0 || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL straight_start: busy=%b pc=%0d cnt=%0d, want 1/0/0", busy0, pc0, cnt0);
        end
        step(128);
        checks++;
        if (busy0 !== 1'b1 || pc0 !== 9'd128 || cnt0 !== 16'd128) begin
            errors++;
            $display("FAIL straight_halt_pc: busy=%b pc=%0d cnt=%0d, want 1/128/128",
                     busy0, pc0, cnt0);
        end
        step(1);
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || pc0 !== 9'd128 || cnt0 !== 16'd128) begin
            errors++;
            $display("FAIL straight_done: done=%b busy=%b pc=%0d cnt=%0d, want 1/0/128/128",
                     done0, busy0, pc0, cnt0);
        end
        step(2);
        checks++;
        if (done0 !== 1'b1 || pc0 !== 9'd128) begin
            errors++;
            $display("FAIL done_hold: done=%b pc=%0d, want 1/128", done0, pc0);
        end
    endtask

    task automatic test_jumps();
        start_run0();
        checks++;
        if (busy0 !== 1'b1 || cnt0 !== 16'd0 || pc0 !== 9'd0) begin
            errors++;
            $display("FAIL restart_from_done: busy=%b pc=%0d cnt=%0d, want 1/0/0", busy0, pc0, cnt0);
        end
        step(5);
        reljump_en = 1'b1; target = 9'h1FD;
        step(1);
        clear_en();
        checks++;
        if (pc0 !== 9'd2) begin
            errors++;
            $display("FAIL rel_jump: pc=%0d want 2", pc0);
        end
        absjump_en = 1'b1; target = 9'd100;
        step(1);
        checks++;
        if (pc0 !== 9'd100) begin
            errors++;
            $display("FAIL abs_jump: pc=%0d want 100", pc0);
        end
        absjump_en = 1'b1; call_en = 1'b1; target = 9'd30;
        step(1);
        clear_en();
        checks++;
        if (pc0 !== 9'd30 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL abs_over_call: pc=%0d busy=%b want 30/1", pc0, busy0);
        end
        // Stack must still be empty, so this ret underflows.
        ret_en = 1'b1;
        step(1);
        clear_en();
        checks++;
        if (fault0 !== 1'b1 || busy0 !== 1'b0 || pc0 !== 9'd30) begin
            errors++;
            $display("FAIL underflow: fault=%b busy=%b pc=%0d want 1/0/30", fault0, busy0, pc0);
        end
    endtask

    task automatic do_call(input logic [8:0] dest);
        call_en = 1'b1; target = dest;
        step(1);
        call_en = 1'b0;
    endtask

    task automatic do_ret();
        ret_en = 1'b1;
        step(1);
        ret_en = 1'b0;
    endtask

    task automatic test_call_ret();
        logic [8:0] dests [4];
        logic [8:0] rets  [4];
        dests = '{9'd20, 9'd30, 9'd40, 9'd60};
        rets  = '{9'd41, 9'd31, 9'd21, 9'd13};
        start_run0();
        step(10);
        do_call(9'd50);
        checks++;
        if (pc0 !== 9'd50) begin
            errors++;
            $display("FAIL call: pc=%0d want 50", pc0);
        end
        step(2);
        do_ret();
        checks++;
        if (pc0 !== 9'd11) begin
            errors++;
            $display("FAIL ret: pc=%0d want 11", pc0);
        end
        do_call(9'd200);
        do_ret();
        checks++;
        if (pc0 !== 9'd12) begin
            errors++;
            $display("FAIL back_to_back: pc=%0d want 12", pc0);
        end
        for (int i = 0; i < 4; i++) do_call(dests[i]);
        checks++;
        if (pc0 !== 9'd60) begin
            errors++;
            $display("FAIL nested_call: pc=%0d want 60", pc0);
        end
        for (int i = 0; i < 4; i++) begin
            do_ret();
            checks++;
            if (pc0 !== rets[i]) begin
                errors++;
                $display("FAIL nested_ret%0d: pc=%0d want %0d", i, pc0, rets[i]);
            end
        end
        for (int i = 0; i < 4; i++) do_call(dests[i]);
        do_call(9'd70);
        checks++;
        if (fault0 !== 1'b1 || busy0 !== 1'b0 || pc0 !== 9'd60) begin
            errors++;
            $display("FAIL overflow: fault=%b busy=%b pc=%0d want 1/0/60", fault0, busy0, pc0);
        end
    endtask

    task automatic test_stall_reset();
        start_run0();
        checks++;
        if (fault0 !== 1'b0 || busy0 !== 1'b1 || pc0 !== 9'd0) begin
            errors++;
            $display("FAIL restart_from_fault: fault=%b busy=%b pc=%0d want 0/1/0",
                     fault0, busy0, pc0);
        end
        step(3);
        stall = 1'b1; absjump_en = 1'b1; target = 9'd77;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (pc0 !== 9'd3 || cnt0 !== 16'd3) begin
                errors++;
                $display("FAIL stall%0d: pc=%0d cnt=%0d want 3/3", i, pc0, cnt0);
            end
        end
        stall = 1'b0; clear_en();
        step(1);
        checks++;
        if (pc0 !== 9'd4 || cnt0 !== 16'd4) begin
            errors++;
            $display("FAIL after_stall: pc=%0d cnt=%0d want 4/4", pc0, cnt0);
        end
        step(36);
        checks++;
        if (pc0 !== 9'd40) begin
            errors++;
            $display("FAIL pre_reset: pc=%0d want 40", pc0);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (pc0 !== 9'd0 || busy0 !== 1'b0 || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: pc=%0d busy=%b cnt=%0d want 0/0/0", pc0, busy0, cnt0);
        end
        reset = 1'b0;
        step(1);
        checks++;
        if (busy0 !== 1'b0 || pc0 !== 9'd0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b pc=%0d want 0/0", busy0, pc0);
        end
    endtask

    task automatic test_wrap();
        logic [8:0] exp_pc;
        req1 = 1'b1;
        step(1);
        req1 = 1'b0;
        exp_pc = 9'd510;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pc1 !== exp_pc || busy1 !== 1'b1) begin
                errors++;
                $display("FAIL wrap%0d: pc=%0d busy=%b want %0d/1", i, pc1, busy1, exp_pc);
            end
            exp_pc = exp_pc + 9'd1;
            step(1);
        end
        checks++;
        if (done1 !== 1'b1 || pc1 !== 9'd5 || cnt1 !== 16'd7) begin
            errors++;
            $display("FAIL wrap_done: done=%b pc=%0d cnt=%0d want 1/5/7", done1, pc1, cnt1);
        end
    endtask

    task automatic test_saturate();
        req2 = 1'b1;
        step(1);
        req2 = 1'b0;
        step(20);
        checks++;
        if (cnt2 !== 4'd15 || busy2 !== 1'b1 || pc2 !== 9'd20) begin
            errors++;
            $display("FAIL saturate: cnt=%0d busy=%b pc=%0d want 15/1/20", cnt2, busy2, pc2);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_jumps();
        test_call_ret();
        test_stall_reset();
        test_wrap();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
